uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver, the counterpart of the CPU's UART transmit path: 8N1, LSB first, line idles high.
//  Synchronises the asynchronous rx pin, finds the start bit and samples each bit at its centre.
//  Holds the received byte until the CPU reads it through a memory-mapped load and acknowledges with rd_en.
//  Reports sticky framing and overrun errors.
// PARAMETERS
//  CLKS_PER_BIT  1085  clk cycles per bit (125 MHz / 115200); legal range >= 4
//  DATA_BITS     8     bits per frame; fixed at 8, parameter kept for the width of the shift logic
// PORTS
//  clk          in   1  system clock; the only clock
//  reset        in   1  asynchronous, active-high reset
//  rx           in   1  serial input pin, asynchronous to clk
//  rd_en        in   1  1-cycle pulse: CPU has consumed rx_data
//  err_clr      in   1  1-cycle pulse: clears frame_err, overrun_err, parity_err
//  rx_data      out  8  last good byte received
//  rx_valid     out  1  rx_data holds an unread byte
//  busy         out  1  FSM is not in IDLE
//  frame_err    out  1  sticky: a stop bit was sampled as 0
//  overrun_err  out  1  sticky: a byte was lost because rx_valid was still set
//  parity_err   out  1  sticky: parity mismatch; tied to 0 when UART_RX_PARITY_EN is not defined
// BEHAVIOUR
//  Reset: sync flops=1, state=IDLE, counters=0, rx_data=8'h00, all flags and rx_valid=0.
//   Reset is honoured at any time, including mid-frame; the partial byte is dropped.
//  Input sync: 2-FF synchroniser; rx_s is the second flop. All decisions use rx_s.
//  Bit counter: cnt is $clog2(CLKS_PER_BIT) bits wide; bit index is 3 bits.
//  IDLE:  rx_s==0 -> START, cnt=0.
//  START: when cnt==CLKS_PER_BIT/2-1, sample rx_s.
//         0 -> DATA, cnt=0, idx=0.  1 -> IDLE (glitch, no flags set).
//  DATA:  when cnt==CLKS_PER_BIT-1, shift rx_s into sr[7] (shift right, so the byte lands LSB first); cnt=0.
//         After idx==7 is sampled -> STOP (or PARITY when the macro is defined).
//  STOP:  when cnt==CLKS_PER_BIT-1, sample rx_s.
//         1 -> deliver the byte (see below), -> IDLE.
//         0 -> frame_err=1, byte discarded, -> BRK.
//  BRK:   wait for rx_s==1 -> IDLE. No new start is detected while in BRK.
//  Delivery (1 cycle after the stop-bit sample):
//   - rx_valid==0: rx_data=sr, rx_valid=1.
//   - rx_valid==1 with rd_en in the same cycle: rx_data=sr, rx_valid stays 1, no overrun.
//   - rx_valid==1 with no rd_en: rx_data unchanged, overrun_err=1.
//  rd_en with no delivery: rx_valid=0 next cycle; rx_data keeps its value. rd_en while rx_valid==0 is ignored.
//  err_clr: clears all error flags next cycle. If an error sets in the same cycle, the set wins.
//  Latency: from the rx falling edge to rx_valid is about 2 + 9.5*CLKS_PER_BIT + 1 cycles.
//  busy=1 in START, DATA, PARITY, STOP and BRK.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - adds a PARITY state between DATA and STOP, one bit time long, even parity.
//   - mismatch -> parity_err=1; the byte is still delivered if the stop bit is good.
//  Not defined:
//   - no PARITY state, frame is 8N1, parity_err is driven 0.
// STRUCTURE
//  Shared define file: state encodings (UART_RX_IDLE/START/DATA/PARITY/STOP/BRK),
//   UART_RX_ADDR for the receive-data/status load address, next to UART_ADDR.
//  Sub-module sync_2ff (parameter RESET_VAL=1): the rx synchroniser, reusable for other async inputs.
//  FSM, counters and holding register live in uart_rx itself.
// TESTING  (bench uses CLKS_PER_BIT=16)
//  1. Send 0xA5, 8N1 -> rx_valid=1, rx_data=8'hA5, frame_err=0, busy returns to 0.
//  2. Pulse rx low for 4 cycles -> no rx_valid, busy falls within 8 cycles, all flags 0.
//  3. Send 0x3C with stop=0, hold rx low for 40 cycles, then send 0x55
//      -> frame_err=1, no delivery of 0x3C; then rx_data=8'h55, rx_valid=1.
//  4. Send 0x11 then 0x22 with no rd_en -> rx_data=8'h11, overrun_err=1.
//      Then rd_en -> rx_valid=0; err_clr -> overrun_err=0.
//  5. rd_en in the same cycle as delivery of 0x33 -> rx_data=8'h33, rx_valid=1, overrun_err=0.
//  6. Assert reset in DATA at bit 4 -> all outputs at reset values; a following 0x5A is received correctly.
//      With UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> parity_err=1, rx_data=8'h07.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings, load addresses
// and the even-parity helper used when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        UART_RX_IDLE   = 3'd0,
        UART_RX_START  = 3'd1,
        UART_RX_DATA   = 3'd2,
        UART_RX_PARITY = 3'd3,
        UART_RX_STOP   = 3'd4,
        UART_RX_BRK    = 3'd5
    } uart_rx_state_t;

    // CPU load addresses: transmit path and receive-data/status register
    localparam logic [31:0] UART_ADDR    = 32'h1000_0000;
    localparam logic [31:0] UART_RX_ADDR = 32'h1000_0004;

    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        return ((^data) ^ par) == 1'b0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is configurable
// so idle-high lines do not produce a spurious edge when reset is released.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // metastability filter: d -> meta -> q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre sampling, one-byte holding register and sticky errors.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
import uart_rx_pkg::*;

module uart_rx #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [2:0]           idx, idx_nx;
    logic [DATA_BITS-1:0] sr, sr_nx;
    logic                 stop_ok, stop_bad;
    logic                 deliver_pend;
    logic                 overrun_set;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // next-state, counters and shift register
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sr_nx    = sr;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad  = 1'b0;
`endif
        case (state)
            UART_RX_IDLE: begin
                if (!rx_s) begin
                    state_nx = UART_RX_START;
                    cnt_nx   = '0;
                end else begin
                    state_nx = UART_RX_IDLE;
                end
            end
            UART_RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    idx_nx   = 3'd0;
                    state_nx = rx_s ? UART_RX_IDLE : UART_RX_DATA;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            UART_RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    sr_nx  = {rx_s, sr[DATA_BITS-1:1]};
                    idx_nx = idx + 3'd1;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = UART_RX_PARITY;
`else
                        state_nx = UART_RX_STOP;
`endif
                    end else begin
                        state_nx = UART_RX_DATA;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            UART_RX_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    par_bad  = !even_parity_ok(sr, rx_s);
                    state_nx = UART_RX_STOP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`endif
            UART_RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        stop_ok  = 1'b1;
                        state_nx = UART_RX_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_nx = UART_RX_BRK;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            UART_RX_BRK: begin
                // a held-low line must return high before a new start bit can count
                if (rx_s) begin
                    state_nx = UART_RX_IDLE;
                end else begin
                    state_nx = UART_RX_BRK;
                end
            end
            default: begin
                state_nx = UART_RX_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign overrun_set = deliver_pend && rx_valid && !rd_en;

    // FSM state, counters and registered busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= UART_RX_IDLE;
            cnt          <= '0;
            idx          <= 3'd0;
            sr           <= '0;
            deliver_pend <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            idx          <= idx_nx;
            sr           <= sr_nx;
            deliver_pend <= stop_ok;
            busy         <= (state_nx != UART_RX_IDLE);
        end
    end

    // holding register and sticky error flags; a set beats err_clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            if (deliver_pend && (!rx_valid || rd_en)) begin
                rx_data  <= sr;
                rx_valid <= 1'b1;
            end else if (rd_en && !deliver_pend) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
            frame_err   <= stop_bad    | (frame_err   & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err  <= par_bad     | (parity_err  & ~err_clr);
`else
            parity_err  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, compared
// every settled cycle against a frame-level model of the holding register and flags.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
    localparam logic PAR_EN = 1'b1;
`else
    localparam int NB = 10;
    localparam logic PAR_EN = 1'b0;
`endif
    // negedge index (from the start-bit falling edge) of the cycle in which the byte is delivered
    localparam int DELIV = 3 + CPB / 2 + CPB * (NB - 1);

    logic       clk = 1'b0;
    logic       reset, rx, rd_en, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, overrun_err, parity_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_data;
    logic       exp_valid, exp_ferr, exp_ovr, exp_perr;
    logic       check_en = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // compare process: outputs against the model whenever the line has settled
    always @(negedge clk) begin
        if (check_en) begin
            check8("rx_data", rx_data, exp_data);
            check1("rx_valid", rx_valid, exp_valid);
            check1("busy", busy, 1'b0);
            check1("frame_err", frame_err, exp_ferr);
            check1("overrun_err", overrun_err, exp_ovr);
            check1("parity_err", parity_err, exp_perr);
        end
    end

    task automatic model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic idle(input int n);
        check_en = 1'b1;
        repeat (n) @(negedge clk);
        check_en = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        exp_perr = 1'b0;
        @(negedge clk);
    endtask

    // one frame; a bad stop bit is followed by 40 more low cycles (a break)
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic bad_par, input logic rd_at);
        logic bits [NB];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = b[i];
        bits[9] = (^b) ^ bad_par;
        bits[NB - 1] = stop_bit;
        for (int k = 0; k < NB * CPB; k++) begin
            rx    = bits[k / CPB];
            rd_en = rd_at && (k == DELIV);
            @(negedge clk);
        end
        rd_en = 1'b0;
        if (!stop_bit) repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        if (bad_par && PAR_EN) exp_perr = 1'b1;
        if (!stop_bit) begin
            exp_ferr = 1'b1;
            if (rd_at) exp_valid = 1'b0;
        end else if (exp_valid && !rd_at) begin
            exp_ovr = 1'b1;
        end else begin
            exp_data  = b;
            exp_valid = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check8("reset_data", rx_data, 8'h00);
        check1("reset_valid", rx_valid, 1'b0);
        check1("reset_busy", busy, 1'b0);
        reset = 1'b0;
        idle(5);

        // clean byte
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check8("t1_data", rx_data, 8'hA5);
        check1("t1_valid", rx_valid, 1'b1);
        idle(5);
        pulse_rd();
        idle(3);

        // short glitch is rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check1("t2_busy", busy, 1'b0);
        check1("t2_valid", rx_valid, 1'b0);
        idle(20);

        // framing error, then recovery
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check1("t3_ferr", frame_err, 1'b1);
        check1("t3_valid", rx_valid, 1'b0);
        idle(5);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check8("t3_data", rx_data, 8'h55);
        idle(5);
        pulse_rd();
        pulse_clr();
        idle(3);

        // overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(3);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check8("t4_data", rx_data, 8'h11);
        check1("t4_ovr", overrun_err, 1'b1);
        idle(3);
        pulse_rd();
        check1("t4_valid_rd", rx_valid, 1'b0);
        pulse_clr();
        check1("t4_ovr_clr", overrun_err, 1'b0);
        idle(3);

        // read in the delivery cycle avoids overrun
        send_frame(8'h44, 1'b1, 1'b0, 1'b0);
        idle(3);
        send_frame(8'h33, 1'b1, 1'b0, 1'b1);
        check8("t5_data", rx_data, 8'h33);
        check1("t5_valid", rx_valid, 1'b1);
        check1("t5_ovr", overrun_err, 1'b0);
        idle(3);

        // reset in the middle of the data bits
        rx = 1'b0;
        repeat (CPB * 4 + CPB / 2 + 4) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        check8("t6_data", rx_data, 8'h00);
        check1("t6_valid", rx_valid, 1'b0);
        check1("t6_busy", busy, 1'b0);
        model_reset();
        reset = 1'b0;
        idle(5);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check8("t6_data_after", rx_data, 8'h5A);
        idle(3);
        pulse_rd();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check1("tp_perr", parity_err, 1'b1);
        check8("tp_data", rx_data, 8'h07);
        idle(3);
        pulse_rd();
        pulse_clr();
`endif

        // randomized frames, reads and clears
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            int act;
            b = 8'($urandom);
            act = $urandom_range(0, 3);
            if (act == 0) pulse_rd();
            if (act == 1) pulse_clr();
            send_frame(b, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1);
            idle($urandom_range(2, 20));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
